frame_dispatcher: RTL and testbench
===================================

Name: frame_dispatcher

Overview:
- Consumes the one-byte phase commands from the frame-counter command FIFO (0 = phase 0, 1 = phase 1).
- For each command, sequences one frame transfer by issuing an address/length request to the downstream data mover and waiting for its completion strobe.
- Each phase owns a ring of frame slots in memory; the block tracks the next slot per phase and keeps per-phase completed-frame counts.
- Sits between the command FIFO output and the data mover's request port; exactly one transfer is outstanding at a time.

Parameters:
- PHASE0_BASE, 64'h0000_0000_1000_0000, byte address of phase-0 slot 0
- PHASE1_BASE, 64'h0000_0000_2000_0000, byte address of phase-1 slot 0
- FRAME_BYTES, 32'h0000_1000, bytes per frame; also the slot stride
- SLOTS, 4, slots per phase ring (1..256)
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT_DONE before abort (>= 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- AXIS_CMD_TDATA  in  8  phase command
- AXIS_CMD_TVALID  in  1  command valid
- AXIS_CMD_TREADY  out  1  command accepted when TVALID & TREADY
- REQ_ADDR  out  64  frame start address
- REQ_BYTES  out  32  frame length, always FRAME_BYTES
- REQ_VALID  out  1  request valid
- REQ_READY  in  1  data mover accepts the request
- XFER_DONE  in  1  single-cycle completion strobe from the data mover
- busy  out  1  state != IDLE
- frame_count0  out  32  completed phase-0 frames
- frame_count1  out  32  completed phase-1 frames
- bad_cmd  out  1  one-cycle pulse: command byte > 1 was dropped
- timeout  out  1  sticky: a transfer timed out

Behaviour:
- Reset values: state IDLE; REQ_VALID 0; REQ_ADDR 0; REQ_BYTES FRAME_BYTES; both slot indices 0; frame_count0/1 0; bad_cmd 0; timeout 0; timer 0.
- Reset has priority over every other event. Asserting reset in ISSUE or WAIT_DONE drops the transfer with no count update. A later XFER_DONE is then ignored.
- AXIS_CMD_TREADY = (state == IDLE) & ~reset. This is the only combinational output.
- States:
  - IDLE: on TVALID & TREADY with TDATA == 0 or 1:
    - latch the phase;
    - REQ_ADDR <= base(phase) + slot(phase) * FRAME_BYTES (64-bit arithmetic);
    - REQ_VALID <= 1;
    - go to ISSUE.
  - IDLE, TDATA > 1: the byte is consumed and dropped; bad_cmd pulses high on the next cycle; the block stays in IDLE.
  - ISSUE: REQ_VALID and REQ_ADDR are held stable until REQ_READY. On REQ_VALID & REQ_READY: REQ_VALID <= 0, timer <= 0, go to WAIT_DONE.
  - WAIT_DONE: timer increments each cycle.
    - On XFER_DONE: increment the phase's frame_count (32-bit, wraps); advance the phase's slot (wraps SLOTS-1 -> 0); go to IDLE.
    - Else, when timer == TIMEOUT_CYCLES-1: timeout <= 1; advance the slot; no count update; go to IDLE.
    - XFER_DONE on the same cycle as the timeout condition counts as a completion, not a timeout.
- XFER_DONE outside WAIT_DONE is ignored.
- Latency: command handshake to REQ_VALID high is 1 cycle. XFER_DONE to TREADY high is 1 cycle. Minimum command-to-command spacing with REQ_READY tied high and XFER_DONE arriving immediately is 3 cycles.
- Slots for phase 0 and phase 1 advance independently. Consecutive same-phase commands are legal.
- timeout clears only on reset.

Optional Feature:
- Macro: FRAME_DISPATCHER_SEQ_CHECK_EN.
- With the macro defined:
  - the block tracks the last accepted valid phase;
  - a valid command equal to the last phase pulses an extra output seq_err for one cycle, registered like bad_cmd;
  - the transfer is still dispatched normally;
  - the first command after reset never flags.
- Without the macro: the seq_err port and its tracking logic do not exist.

Test Plan:
All scenarios use PHASE0_BASE=0x1000_0000, PHASE1_BASE=0x2000_0000, FRAME_BYTES=0x1000, SLOTS=4, TIMEOUT_CYCLES=16.
- Commands 0,1,0,1, REQ_READY=1, XFER_DONE 2 cycles after the request handshake -> REQ_ADDR sequence 0x1000_0000, 0x2000_0000, 0x1000_1000, 0x2000_1000; frame_count0=2, frame_count1=2; REQ_BYTES=0x1000 throughout.
- Five phase-0 commands -> addresses 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, 0x1000_0000 (slot wrap); frame_count0=5.
- Command 0 with REQ_READY held low for 10 cycles -> REQ_VALID and REQ_ADDR stable for all 10 cycles; TREADY=0; handshake completes on the first cycle REQ_READY=1.
- Command 1, XFER_DONE never asserted -> timeout=1 exactly 16 cycles after the handshake; frame_count1 unchanged; the next command 1 issues 0x2000_1000; a late XFER_DONE is ignored.
- Command byte 0x05 -> TREADY=1; no REQ_VALID; bad_cmd high for one cycle; counts and slots unchanged.
- Reset pulsed in WAIT_DONE, then XFER_DONE -> all outputs at reset values; counts stay 0; the next command 0 issues 0x1000_0000.

Source files
------------

// File: rtl/frame_dispatcher.sv
// frame_dispatcher: turns one-byte phase commands into single outstanding frame transfers
// over per-phase slot rings. Define FRAME_DISPATCHER_SEQ_CHECK_EN to add the seq_err output.
module frame_dispatcher #(
   parameter logic [63:0] PHASE0_BASE    = 64'h0000_0000_1000_0000,
   parameter logic [63:0] PHASE1_BASE    = 64'h0000_0000_2000_0000,
   parameter logic [31:0] FRAME_BYTES    = 32'h0000_1000,
   parameter int          SLOTS          = 4,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  AXIS_CMD_TDATA,
   input  logic        AXIS_CMD_TVALID,
   output logic        AXIS_CMD_TREADY,
   output logic [63:0] REQ_ADDR,
   output logic [31:0] REQ_BYTES,
   output logic        REQ_VALID,
   input  logic        REQ_READY,
   input  logic        XFER_DONE,
   output logic        busy,
   output logic [31:0] frame_count0,
   output logic [31:0] frame_count1,
   output logic        bad_cmd,
`ifdef FRAME_DISPATCHER_SEQ_CHECK_EN
   output logic        seq_err,
`endif
   output logic        timeout
);

   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

   state_e                state_q, state_d;
   logic                  phase_q, phase_d;
   logic [1:0][SW-1:0]    slot_q, slot_d;
   logic [1:0][31:0]      count_q, count_d;
   logic [63:0]           req_addr_q, req_addr_d;
   logic                  req_valid_q, req_valid_d;
   logic                  bad_cmd_q, bad_cmd_d;
   logic                  timeout_q, timeout_d;
   logic [TW-1:0]         timer_q, timer_d;

   logic cmd_fire;
   logic cmd_ok;
   logic tick_last;

   assign cmd_fire  = AXIS_CMD_TVALID & AXIS_CMD_TREADY;
   assign cmd_ok    = (AXIS_CMD_TDATA[7:1] == 7'd0);
   assign tick_last = (timer_q == LAST_TICK);

   function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
      return (s == LAST_SLOT) ? '0 : s + SW'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         slot_q      <= '0;
         count_q     <= '0;
         req_addr_q  <= '0;
         req_valid_q <= 1'b0;
         bad_cmd_q   <= 1'b0;
         timeout_q   <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         slot_q      <= slot_d;
         count_q     <= count_d;
         req_addr_q  <= req_addr_d;
         req_valid_q <= req_valid_d;
         bad_cmd_q   <= bad_cmd_d;
         timeout_q   <= timeout_d;
         timer_q     <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cmd_fire && cmd_ok) state_d = ISSUE;
         ISSUE:     if (REQ_READY) state_d = WAIT_DONE;
         WAIT_DONE: if (XFER_DONE || tick_last) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // NOTE: every comb-assigned signal gets a default first so no latch is inferred.
   always_comb begin
      phase_d     = phase_q;
      slot_d      = slot_q;
      count_d     = count_q;
      req_addr_d  = req_addr_q;
      req_valid_d = req_valid_q;
      bad_cmd_d   = 1'b0;
      timeout_d   = timeout_q;
      timer_d     = timer_q;
      case (state_q)
         IDLE: begin
            if (cmd_fire && cmd_ok) begin
               phase_d     = AXIS_CMD_TDATA[0];
               req_addr_d  = (AXIS_CMD_TDATA[0] ? PHASE1_BASE : PHASE0_BASE)
                           + 64'(slot_q[AXIS_CMD_TDATA[0]]) * 64'(FRAME_BYTES);
               req_valid_d = 1'b1;
            end else if (cmd_fire) begin
               bad_cmd_d = 1'b1;
            end
         end
         ISSUE: begin
            if (REQ_READY) begin
               req_valid_d = 1'b0;
               timer_d     = '0;
            end
         end
         WAIT_DONE: begin
            timer_d = timer_q + TW'(1);
            // A completion on the timeout cycle wins over the abort.
            if (XFER_DONE) begin
               count_d[phase_q] = count_q[phase_q] + 32'd1;
               slot_d[phase_q]  = next_slot(slot_q[phase_q]);
            end else if (tick_last) begin
               timeout_d        = 1'b1;
               slot_d[phase_q]  = next_slot(slot_q[phase_q]);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      AXIS_CMD_TREADY = (state_q == IDLE) & ~reset;
      busy            = (state_q != IDLE);
   end

   assign REQ_ADDR     = req_addr_q;
   assign REQ_BYTES    = FRAME_BYTES;
   assign REQ_VALID    = req_valid_q;
   assign frame_count0 = count_q[0];
   assign frame_count1 = count_q[1];
   assign bad_cmd      = bad_cmd_q;
   assign timeout      = timeout_q;

`ifdef FRAME_DISPATCHER_SEQ_CHECK_EN
   logic last_vld_q, last_vld_d;
   logic last_phase_q, last_phase_d;
   logic seq_err_q, seq_err_d;

   always_comb begin
      last_vld_d   = last_vld_q;
      last_phase_d = last_phase_q;
      seq_err_d    = 1'b0;
      if (cmd_fire && cmd_ok) begin
         seq_err_d    = last_vld_q && (AXIS_CMD_TDATA[0] == last_phase_q);
         last_vld_d   = 1'b1;
         last_phase_d = AXIS_CMD_TDATA[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_vld_q   <= 1'b0;
         last_phase_q <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         last_vld_q   <= last_vld_d;
         last_phase_q <= last_phase_d;
         seq_err_q    <= seq_err_d;
      end
   end

   assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_frame_dispatcher.sv
// Self-checking bench for frame_dispatcher: directed scenarios plus a randomized run
// against a slot/count reference model.
module tb_frame_dispatcher;

   localparam logic [63:0] P0_BASE = 64'h0000_0000_1000_0000;
   localparam logic [63:0] P1_BASE = 64'h0000_0000_2000_0000;
   localparam logic [31:0] FB      = 32'h0000_1000;
   localparam int          NSLOT   = 4;
   localparam int          TMO     = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  AXIS_CMD_TDATA = '0;
   logic        AXIS_CMD_TVALID = 1'b0;
   logic        AXIS_CMD_TREADY;
   logic [63:0] REQ_ADDR;
   logic [31:0] REQ_BYTES;
   logic        REQ_VALID;
   logic        REQ_READY = 1'b0;
   logic        XFER_DONE = 1'b0;
   logic        busy;
   logic [31:0] frame_count0, frame_count1;
   logic        bad_cmd, timeout;
`ifdef FRAME_DISPATCHER_SEQ_CHECK_EN
   logic        seq_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: next slot and completed count per phase, sticky timeout.
   int          m_slot[2];
   int unsigned m_cnt[2];
   logic        m_to;

   always #5 clk = ~clk;

   frame_dispatcher #(
      .PHASE0_BASE(P0_BASE), .PHASE1_BASE(P1_BASE), .FRAME_BYTES(FB),
      .SLOTS(NSLOT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .AXIS_CMD_TDATA(AXIS_CMD_TDATA), .AXIS_CMD_TVALID(AXIS_CMD_TVALID),
      .AXIS_CMD_TREADY(AXIS_CMD_TREADY),
      .REQ_ADDR(REQ_ADDR), .REQ_BYTES(REQ_BYTES), .REQ_VALID(REQ_VALID),
      .REQ_READY(REQ_READY), .XFER_DONE(XFER_DONE), .busy(busy),
      .frame_count0(frame_count0), .frame_count1(frame_count1),
      .bad_cmd(bad_cmd),
`ifdef FRAME_DISPATCHER_SEQ_CHECK_EN
      .seq_err(seq_err),
`endif
      .timeout(timeout)
   );

   function automatic logic [63:0] model_addr(input int p);
      return (p == 1 ? P1_BASE : P0_BASE) + 64'(m_slot[p]) * 64'(FB);
   endfunction

   task automatic model_reset();
      m_slot[0] = 0; m_slot[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_to = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; AXIS_CMD_TVALID = 1'b0; REQ_READY = 1'b0; XFER_DONE = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One command through handshake; returns on the negedge after the request handshake
   // when done_dly < 0, otherwise after XFER_DONE has been pulsed done_dly cycles later.
   task automatic xfer(input logic [7:0] b, input int rdy_dly, input int done_dly,
                       output logic [63:0] addr, output logic ok);
      @(negedge clk);
      AXIS_CMD_TDATA = b; AXIS_CMD_TVALID = 1'b1;
      @(negedge clk);
      AXIS_CMD_TVALID = 1'b0;
      ok   = (REQ_VALID === 1'b1);
      addr = REQ_ADDR;
      repeat (rdy_dly) @(negedge clk);
      REQ_READY = 1'b1;
      @(negedge clk);
      REQ_READY = 1'b0;
      if (REQ_VALID !== 1'b0) ok = 1'b0;
      if (done_dly >= 0) begin
         repeat (done_dly) @(negedge clk);
         XFER_DONE = 1'b1;
         @(negedge clk);
         XFER_DONE = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (AXIS_CMD_TREADY !== 1'b0) begin n_fail++; $display("FAIL rst_tready_in_reset: got %b want 0", AXIS_CMD_TREADY); end
      n_checks++;
      if ({REQ_VALID, busy, bad_cmd, timeout} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {REQ_VALID, busy, bad_cmd, timeout}); end
      n_checks++;
      if (REQ_ADDR !== 64'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", REQ_ADDR); end
      n_checks++;
      if (REQ_BYTES !== FB) begin n_fail++; $display("FAIL rst_bytes: got %h want %h", REQ_BYTES, FB); end
      n_checks++;
      if ({frame_count0, frame_count1} !== 64'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", frame_count0, frame_count1); end
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (AXIS_CMD_TREADY !== 1'b1) begin n_fail++; $display("FAIL rst_tready_after: got %b want 1", AXIS_CMD_TREADY); end
   endtask

   task automatic test_alternate();
      logic [63:0] a, e;
      logic ok;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         e = model_addr(i % 2);
         xfer(8'(i % 2), 0, 1, a, ok);
         m_cnt[i % 2]++; m_slot[i % 2] = (m_slot[i % 2] + 1) % NSLOT;
         n_checks++;
         if (a !== e || !ok) begin n_fail++; $display("FAIL alt_addr[%0d]: got %h ok=%b want %h", i, a, ok, e); end
         n_checks++;
         if (REQ_BYTES !== FB) begin n_fail++; $display("FAIL alt_bytes[%0d]: got %h want %h", i, REQ_BYTES, FB); end
      end
      n_checks++;
      if (frame_count0 !== 32'd2 || frame_count1 !== 32'd2) begin n_fail++; $display("FAIL alt_counts: got %0d/%0d want 2/2", frame_count0, frame_count1); end
   endtask

   task automatic test_slot_wrap();
      logic [63:0] a, e;
      logic ok;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         e = model_addr(0);
         xfer(8'd0, 0, 0, a, ok);
         m_cnt[0]++; m_slot[0] = (m_slot[0] + 1) % NSLOT;
         n_checks++;
         if (a !== e || !ok) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h ok=%b want %h", i, a, ok, e); end
      end
      n_checks++;
      if (frame_count0 !== 32'd5 || frame_count1 !== 32'd0) begin n_fail++; $display("FAIL wrap_counts: got %0d/%0d want 5/0", frame_count0, frame_count1); end
   endtask

   task automatic test_backpressure();
      logic [63:0] e;
      int bad;
      do_reset();
      e = model_addr(0);
      @(negedge clk);
      AXIS_CMD_TDATA = 8'd0; AXIS_CMD_TVALID = 1'b1;
      @(negedge clk);
      AXIS_CMD_TVALID = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (REQ_VALID !== 1'b1 || REQ_ADDR !== e || AXIS_CMD_TREADY !== 1'b0) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_stable: %0d of 10 cycles unstable, want 0 (addr %h want %h)", bad, REQ_ADDR, e); end
      REQ_READY = 1'b1;
      @(negedge clk);
      REQ_READY = 1'b0;
      n_checks++;
      if (REQ_VALID !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_handshake: valid=%b busy=%b want 0/1", REQ_VALID, busy); end
      XFER_DONE = 1'b1;
      @(negedge clk);
      XFER_DONE = 1'b0;
      m_cnt[0]++; m_slot[0] = (m_slot[0] + 1) % NSLOT;
      n_checks++;
      if (frame_count0 !== m_cnt[0] || busy !== 1'b0) begin n_fail++; $display("FAIL bp_done: count0=%0d busy=%b want %0d/0", frame_count0, busy, m_cnt[0]); end
   endtask

   task automatic test_timeout();
      logic [63:0] a, e;
      logic ok;
      int to_at;
      do_reset();
      xfer(8'd1, 0, -1, a, ok);
      to_at = -1;
      for (int k = 1; k <= 40 && to_at < 0; k++) begin
         @(negedge clk);
         if (timeout === 1'b1) to_at = k;
      end
      m_slot[1] = (m_slot[1] + 1) % NSLOT; m_to = 1'b1;
      n_checks++;
      if (to_at != TMO) begin n_fail++; $display("FAIL to_latency: got %0d cycles want %0d", to_at, TMO); end
      n_checks++;
      if (frame_count1 !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_state: count1=%0d busy=%b want 0/0", frame_count1, busy); end
      XFER_DONE = 1'b1;
      @(negedge clk);
      XFER_DONE = 1'b0;
      @(negedge clk);
      n_checks++;
      if (frame_count0 !== 32'd0 || frame_count1 !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_late_done: counts %0d/%0d busy=%b want 0/0/0", frame_count0, frame_count1, busy); end
      e = model_addr(1);
      xfer(8'd1, 0, 1, a, ok);
      m_cnt[1]++; m_slot[1] = (m_slot[1] + 1) % NSLOT;
      n_checks++;
      if (a !== e || !ok) begin n_fail++; $display("FAIL to_next_addr: got %h want %h", a, e); end
      n_checks++;
      if (timeout !== 1'b1 || frame_count1 !== m_cnt[1]) begin n_fail++; $display("FAIL to_sticky: timeout=%b count1=%0d want 1/%0d", timeout, frame_count1, m_cnt[1]); end
   endtask

   task automatic test_bad_cmd();
      logic [63:0] a, e;
      logic ok;
      do_reset();
      @(negedge clk);
      AXIS_CMD_TDATA = 8'h05; AXIS_CMD_TVALID = 1'b1;
      n_checks++;
      if (AXIS_CMD_TREADY !== 1'b1) begin n_fail++; $display("FAIL bad_tready: got %b want 1", AXIS_CMD_TREADY); end
      @(negedge clk);
      AXIS_CMD_TVALID = 1'b0;
      n_checks++;
      if (bad_cmd !== 1'b1 || REQ_VALID !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_pulse: bad=%b valid=%b busy=%b want 1/0/0", bad_cmd, REQ_VALID, busy); end
      @(negedge clk);
      n_checks++;
      if (bad_cmd !== 1'b0) begin n_fail++; $display("FAIL bad_one_cycle: got %b want 0", bad_cmd); end
      e = model_addr(0);
      xfer(8'd0, 0, 1, a, ok);
      m_cnt[0]++; m_slot[0] = (m_slot[0] + 1) % NSLOT;
      n_checks++;
      if (a !== e || frame_count0 !== m_cnt[0] || frame_count1 !== 32'd0) begin n_fail++; $display("FAIL bad_after: addr %h counts %0d/%0d want %h %0d/0", a, frame_count0, frame_count1, e, m_cnt[0]); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] a, e;
      logic ok;
      do_reset();
      xfer(8'd0, 0, -1, a, ok);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      n_checks++;
      if ({REQ_VALID, busy, bad_cmd, timeout} !== 4'b0 || REQ_ADDR !== 64'd0) begin n_fail++; $display("FAIL mid_reset_vals: flags=%b addr=%h want 0000/0", {REQ_VALID, busy, bad_cmd, timeout}, REQ_ADDR); end
      XFER_DONE = 1'b1;
      @(negedge clk);
      XFER_DONE = 1'b0;
      n_checks++;
      if (frame_count0 !== 32'd0 || frame_count1 !== 32'd0) begin n_fail++; $display("FAIL mid_counts: got %0d/%0d want 0/0", frame_count0, frame_count1); end
      e = model_addr(0);
      xfer(8'd0, 0, 0, a, ok);
      m_cnt[0]++; m_slot[0] = (m_slot[0] + 1) % NSLOT;
      n_checks++;
      if (a !== e || !ok) begin n_fail++; $display("FAIL mid_next_addr: got %h want %h", a, e); end
   endtask

   task automatic test_random();
      logic [63:0] a, e;
      logic ok;
      int r, p, rd, dd;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 9) begin
            @(negedge clk);
            AXIS_CMD_TDATA = 8'($urandom_range(2, 255)); AXIS_CMD_TVALID = 1'b1;
            @(negedge clk);
            AXIS_CMD_TVALID = 1'b0;
            n_checks++;
            if (bad_cmd !== 1'b1 || REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL rnd_bad[%0d]: bad=%b valid=%b want 1/0", i, bad_cmd, REQ_VALID); end
         end else begin
            p  = (r < 5) ? 0 : 1;
            rd = int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            e  = model_addr(p);
            xfer(8'(p), rd, dd, a, ok);
            if (dd < 0) begin
               repeat (TMO + 1) @(negedge clk);
               m_to = 1'b1;
            end else begin
               m_cnt[p]++;
            end
            m_slot[p] = (m_slot[p] + 1) % NSLOT;
            n_checks++;
            if (a !== e || !ok) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h ok=%b want %h", i, a, ok, e); end
         end
         n_checks++;
         if (frame_count0 !== m_cnt[0] || frame_count1 !== m_cnt[1] || timeout !== m_to || busy !== 1'b0)
            begin n_fail++; $display("FAIL rnd_state[%0d]: counts %0d/%0d to=%b busy=%b want %0d/%0d %b 0", i, frame_count0, frame_count1, timeout, busy, m_cnt[0], m_cnt[1], m_to); end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_alternate();
      test_slot_wrap();
      test_backpressure();
      test_timeout();
      test_bad_cmd();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
